// File: rtl/cluster_count_monitor_pkg.sv
// -----------------------------------------------------------------------------
// cluster_count_monitor_pkg
// Shared definitions for the cluster count monitor:
//   - CNT_BITS_DEF : default width of the per-BX cluster count
//   - state_t      : monitor FSM encoding (IDLE, RUN)
//   - sat_add      : saturating unsigned add clipped to a given bit width
// -----------------------------------------------------------------------------
package cluster_count_monitor_pkg;

    // Default cluster count width (count range 0..1536 fits in 11 bits)
    localparam int CNT_BITS_DEF = 11;

    // Monitor FSM encoding
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Unsigned add of two operands that are already below 2^bits; the result
    // is clipped to 2^bits-1 instead of wrapping. Operands are carried in 64
    // bits so the raw sum can never overflow for any width up to 63.
    function automatic logic [63:0] sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input int unsigned bits
    );
        logic [63:0] limit;
        logic [63:0] raw;
        if (bits >= 32'd64) begin
            limit = {64{1'b1}};
        end else begin
            limit = (64'd1 << bits) - 64'd1;
        end
        raw = a + b;
        if (raw > limit) begin
            return limit;
        end else begin
            return raw;
        end
    endfunction

endpackage : cluster_count_monitor_pkg

// File: rtl/cluster_window_accum.sv
// -----------------------------------------------------------------------------
// cluster_window_accum
// Window accumulators for the cluster count monitor: running sum (saturating),
// peak count, overflow-BX tally (saturating) and sample counter.
//
// The *_total outputs are combinational and already include the sample being
// presented this cycle, so the top can load a snapshot on the same edge that
// the accumulators clear. close is asserted for the sample that makes the
// sample count reach len.
//
// Ports:
//   clock         in   fabric clock
//   reset         in   synchronous, active-high
//   clear         in   hold all accumulators at zero
//   sample_valid  in   a qualified sample is present this cycle
//   cnt           in   cluster count of the sample
//   overflow      in   overflow flag of the sample
//   len           in   latched window length (never zero)
//   close         out  this sample closes the window
//   sum_total     out  sum including this sample
//   max_total     out  peak including this sample
//   ovf_total     out  overflow tally including this sample
//   n_total       out  sample count including this sample
// -----------------------------------------------------------------------------
module cluster_window_accum
    import cluster_count_monitor_pkg::*;
#(
    parameter int CNT_BITS = CNT_BITS_DEF,
    parameter int WIN_BITS = 24,
    parameter int ACC_BITS = 32,
    parameter int OVF_BITS = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                sample_valid,
    input  logic [CNT_BITS-1:0] cnt,
    input  logic                overflow,
    input  logic [WIN_BITS-1:0] len,
    output logic                close,
    output logic [ACC_BITS-1:0] sum_total,
    output logic [CNT_BITS-1:0] max_total,
    output logic [OVF_BITS-1:0] ovf_total,
    output logic [WIN_BITS-1:0] n_total
);

    logic [ACC_BITS-1:0] sum_r;
    logic [CNT_BITS-1:0] max_r;
    logic [OVF_BITS-1:0] ovf_r;
    logic [WIN_BITS-1:0] n_r;

    logic [63:0]         sum_wide_s;
    logic [63:0]         ovf_wide_s;

    // Totals including the current sample, plus the window-close decision
    always_comb begin
        sum_wide_s = 64'd0;
        ovf_wide_s = 64'd0;
        sum_total  = sum_r;
        max_total  = max_r;
        ovf_total  = ovf_r;
        n_total    = n_r;
        close      = 1'b0;
        if (sample_valid) begin
            sum_wide_s = sat_add(64'(sum_r), 64'(cnt), ACC_BITS);
            ovf_wide_s = sat_add(64'(ovf_r), 64'(overflow), OVF_BITS);
            sum_total  = sum_wide_s[ACC_BITS-1:0];
            ovf_total  = ovf_wide_s[OVF_BITS-1:0];
            if (cnt > max_r) begin
                max_total = cnt;
            end else begin
                max_total = max_r;
            end
            // n_r is always below len, so n_r+1 cannot wrap
            n_total = n_r + {{(WIN_BITS-1){1'b0}}, 1'b1};
            close   = (n_total == len);
        end else begin
            close = 1'b0;
        end
    end

    // Accumulator state: cleared on idle or close, otherwise takes the totals
    always_ff @(posedge clock) begin
        if (reset || clear || close) begin
            sum_r <= '0;
            max_r <= '0;
            ovf_r <= '0;
            n_r   <= '0;
        end else if (sample_valid) begin
            sum_r <= sum_total;
            max_r <= max_total;
            ovf_r <= ovf_total;
            n_r   <= n_total;
        end else begin
            sum_r <= sum_r;
            max_r <= max_r;
            ovf_r <= ovf_r;
            n_r   <= n_r;
        end
    end

endmodule : cluster_window_accum

// File: rtl/cluster_count_monitor.sv
// -----------------------------------------------------------------------------
// cluster_count_monitor
// Accumulates the per-BX cluster count over a programmable window of valid
// samples and publishes each closed window (sum, peak, overflow tally, sample
// count) as a snapshot through a valid/ack handshake. Accumulation continues
// while a snapshot waits; a window that closes while the previous snapshot is
// still unread is dropped and flagged on the sticky lost_o.
//
// Ports:
//   clock         in   fabric clock, one count sample per clock
//   reset         in   synchronous, active-high
//   cnt_i         in   cluster count for this BX
//   overflow_i    in   count exceeded overflow threshold this BX
//   valid_i       in   sample qualifier
//   enable_i      in   run monitor; low = idle, partial window discarded
//   window_len_i  in   valid samples per window; 0 is treated as 1
//   snap_valid_o  out  snapshot outputs hold a closed window
//   snap_ack_i    in   consumer takes snapshot
//   sum_o         out  sum of cnt over window, saturating
//   max_o         out  peak cnt in window
//   ovf_cnt_o     out  overflow BXs in window, saturating
//   samples_o     out  samples in window
//   lost_o        out  sticky: a closed window was dropped
// -----------------------------------------------------------------------------
module cluster_count_monitor
    import cluster_count_monitor_pkg::*;
#(
    parameter int CNT_BITS = CNT_BITS_DEF,
    parameter int WIN_BITS = 24,
    parameter int ACC_BITS = 32,
    parameter int OVF_BITS = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CNT_BITS-1:0] cnt_i,
    input  logic                overflow_i,
    input  logic                valid_i,
    input  logic                enable_i,
    input  logic [WIN_BITS-1:0] window_len_i,
    output logic                snap_valid_o,
    input  logic                snap_ack_i,
    output logic [ACC_BITS-1:0] sum_o,
    output logic [CNT_BITS-1:0] max_o,
    output logic [OVF_BITS-1:0] ovf_cnt_o,
    output logic [WIN_BITS-1:0] samples_o,
    output logic                lost_o
);

    // Input stage
    logic [CNT_BITS-1:0] cnt_r;
    logic                ovf_r;
    logic                valid_r;

    // Control
    state_t              state_r;
    logic [WIN_BITS-1:0] len_r;
    logic [WIN_BITS-1:0] len_norm_s;
    logic                active_s;

    // Accumulator interface
    logic                close_s;
    logic [ACC_BITS-1:0] sum_total_s;
    logic [CNT_BITS-1:0] max_total_s;
    logic [OVF_BITS-1:0] ovf_total_s;
    logic [WIN_BITS-1:0] n_total_s;

    // Snapshot register
    logic                snap_valid_r;
    logic [ACC_BITS-1:0] snap_sum_r;
    logic [CNT_BITS-1:0] snap_max_r;
    logic [OVF_BITS-1:0] snap_ovf_r;
    logic [WIN_BITS-1:0] snap_n_r;
    logic                lost_r;

    // Register the raw sample once before it reaches the accumulators
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r   <= '0;
            ovf_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_i;
            ovf_r   <= overflow_i;
            valid_r <= valid_i;
        end
    end

    // Window length as latched: a zero request means one sample per window;
    // accumulation is live only in RUN while enable_i holds, so a drop of
    // enable_i discards the partial window immediately
    always_comb begin
        if (window_len_i == {WIN_BITS{1'b0}}) begin
            len_norm_s = {{(WIN_BITS-1){1'b0}}, 1'b1};
        end else begin
            len_norm_s = window_len_i;
        end
        active_s = (state_r == ST_RUN) && enable_i;
    end

    // Monitor FSM; window length is re-latched only when a window starts
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            len_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable_i) begin
                        state_r <= ST_RUN;
                        len_r   <= len_norm_s;
                    end else begin
                        state_r <= ST_IDLE;
                        len_r   <= len_r;
                    end
                end
                ST_RUN: begin
                    if (!enable_i) begin
                        state_r <= ST_IDLE;
                        len_r   <= len_r;
                    end else if (close_s) begin
                        state_r <= ST_RUN;
                        len_r   <= len_norm_s;
                    end else begin
                        state_r <= ST_RUN;
                        len_r   <= len_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    len_r   <= '0;
                end
            endcase
        end
    end

    cluster_window_accum #(
        .CNT_BITS (CNT_BITS),
        .WIN_BITS (WIN_BITS),
        .ACC_BITS (ACC_BITS),
        .OVF_BITS (OVF_BITS)
    ) u_accum (
        .clock        (clock),
        .reset        (reset),
        .clear        (!active_s),
        .sample_valid (valid_r && active_s),
        .cnt          (cnt_r),
        .overflow     (ovf_r),
        .len          (len_r),
        .close        (close_s),
        .sum_total    (sum_total_s),
        .max_total    (max_total_s),
        .ovf_total    (ovf_total_s),
        .n_total      (n_total_s)
    );

    // Snapshot register and handshake. An ack in the same cycle as a close
    // frees the slot, so the new window loads and snap_valid stays high.
    always_ff @(posedge clock) begin
        if (reset) begin
            snap_valid_r <= 1'b0;
            snap_sum_r   <= '0;
            snap_max_r   <= '0;
            snap_ovf_r   <= '0;
            snap_n_r     <= '0;
            lost_r       <= 1'b0;
        end else if (close_s) begin
            if (!snap_valid_r || snap_ack_i) begin
                snap_valid_r <= 1'b1;
                snap_sum_r   <= sum_total_s;
                snap_max_r   <= max_total_s;
                snap_ovf_r   <= ovf_total_s;
                snap_n_r     <= n_total_s;
            end else begin
                lost_r <= 1'b1;
            end
        end else if (snap_valid_r && snap_ack_i) begin
            snap_valid_r <= 1'b0;
        end else begin
            snap_valid_r <= snap_valid_r;
        end
    end

    assign snap_valid_o = snap_valid_r;
    assign sum_o        = snap_sum_r;
    assign max_o        = snap_max_r;
    assign ovf_cnt_o    = snap_ovf_r;
    assign samples_o    = snap_n_r;
    assign lost_o       = lost_r;

endmodule : cluster_count_monitor

// File: tb/tb_cluster_count_monitor.sv
// -----------------------------------------------------------------------------
// tb_cluster_count_monitor
// Directed scoreboard bench: stimulus pushes hand-computed snapshots (with the
// cycle they must appear on) into a queue; a monitor pops and compares each
// time the DUT presents a fresh snapshot.
// -----------------------------------------------------------------------------
module tb_cluster_count_monitor;

    localparam int CNT_BITS = 11;
    localparam int WIN_BITS = 24;
    localparam int ACC_BITS = 12;
    localparam int OVF_BITS = 16;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [CNT_BITS-1:0] cnt_i = '0;
    logic                overflow_i = 1'b0;
    logic                valid_i = 1'b0;
    logic                enable_i = 1'b0;
    logic [WIN_BITS-1:0] window_len_i = '0;
    logic                snap_ack_i = 1'b0;
    logic                snap_valid_o;
    logic [ACC_BITS-1:0] sum_o;
    logic [CNT_BITS-1:0] max_o;
    logic [OVF_BITS-1:0] ovf_cnt_o;
    logic [WIN_BITS-1:0] samples_o;
    logic                lost_o;

    typedef struct {
        longint sum;
        longint mx;
        longint ovf;
        longint n;
        int     cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   cur   = 0;

    cluster_count_monitor #(
        .CNT_BITS (CNT_BITS),
        .WIN_BITS (WIN_BITS),
        .ACC_BITS (ACC_BITS),
        .OVF_BITS (OVF_BITS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cnt_i        (cnt_i),
        .overflow_i   (overflow_i),
        .valid_i      (valid_i),
        .enable_i     (enable_i),
        .window_len_i (window_len_i),
        .snap_valid_o (snap_valid_o),
        .snap_ack_i   (snap_ack_i),
        .sum_o        (sum_o),
        .max_o        (max_o),
        .ovf_cnt_o    (ovf_cnt_o),
        .samples_o    (samples_o),
        .lost_o       (lost_o)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present one BX worth of inputs for one cycle
    task automatic drive(input logic v, input int c, input logic o, input logic a);
        logic [31:0] cv;
        @(posedge clock);
        #1;
        cv         = c;
        valid_i    = v;
        cnt_i      = cv[CNT_BITS-1:0];
        overflow_i = o;
        snap_ack_i = a;
        cur        = cyc;
    endtask

    // Expected snapshot for a window whose last sample was driven this cycle
    task automatic push(input longint s, input longint m, input longint o, input longint n);
        exp_t e;
        e.sum = s; e.mx = m; e.ovf = o; e.n = n; e.cyc = cur + 2;
        q.push_back(e);
    endtask

    // Drop to IDLE for a cycle, then start a fresh window of length len
    task automatic restart(input int len);
        @(posedge clock);
        #1;
        enable_i   = 1'b0;
        valid_i    = 1'b0;
        snap_ack_i = 1'b0;
        @(posedge clock);
        #1;
        window_len_i = len[WIN_BITS-1:0];
        enable_i     = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for a snapshot, ack it, and check valid drops next cycle
    task automatic ack_snapshot(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 0, 1'b0, 1'b0);
            @(negedge clock);
            if (snap_valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_wait: snapshot never appeared within 20 cycles", name);
        end
        drive(1'b0, 0, 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b0);
        @(negedge clock);
        check({name, "_valid_after_ack"}, longint'(snap_valid_o), 64'sd0);
    endtask

    // Scoreboard monitor: a snapshot is fresh when valid rises or follows an ack
    initial begin : monitor
        logic prev_v;
        logic prev_a;
        exp_t e;
        prev_v = 1'b0;
        prev_a = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_v = 1'b0;
                prev_a = 1'b0;
            end else begin
                if (snap_valid_o && (!prev_v || prev_a)) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_snapshot: sum=%0d at cycle %0d, none expected",
                                 sum_o, cyc);
                    end else begin
                        e = q.pop_front();
                        check("snap_sum", longint'(sum_o), e.sum);
                        check("snap_max", longint'(max_o), e.mx);
                        check("snap_ovf", longint'(ovf_cnt_o), e.ovf);
                        check("snap_samples", longint'(samples_o), e.n);
                        check("snap_cycle", longint'(cyc), longint'(e.cyc));
                    end
                end
                prev_v = snap_valid_o;
                prev_a = snap_ack_i;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_snap_valid", longint'(snap_valid_o), 64'sd0);
        check("rst_sum", longint'(sum_o), 64'sd0);
        check("rst_max", longint'(max_o), 64'sd0);
        check("rst_ovf", longint'(ovf_cnt_o), 64'sd0);
        check("rst_samples", longint'(samples_o), 64'sd0);
        check("rst_lost", longint'(lost_o), 64'sd0);

        // len=4: 10,20,30,40 -> sum 100, max 40
        restart(4);
        drive(1'b1, 10, 1'b0, 1'b0);
        drive(1'b1, 20, 1'b0, 1'b0);
        drive(1'b1, 30, 1'b0, 1'b0);
        drive(1'b1, 40, 1'b0, 1'b0);
        push(100, 40, 0, 4);
        ack_snapshot("t1");

        // len=3: valid 1,0,1,0,1 cnt=5, overflow on 2nd valid; invalid BXs
        // carry junk that must be ignored
        restart(3);
        drive(1'b1, 5, 1'b0, 1'b0);
        drive(1'b0, 99, 1'b1, 1'b0);
        drive(1'b1, 5, 1'b1, 1'b0);
        drive(1'b0, 99, 1'b1, 1'b0);
        drive(1'b1, 5, 1'b0, 1'b0);
        push(15, 5, 1, 3);
        ack_snapshot("t2");

        // len=2: ack lands on the cycle the second window closes
        restart(2);
        drive(1'b1, 100, 1'b0, 1'b0);
        drive(1'b1, 200, 1'b0, 1'b0);
        push(300, 200, 0, 2);
        drive(1'b1, 300, 1'b0, 1'b0);
        drive(1'b1, 50, 1'b0, 1'b0);
        push(350, 300, 0, 2);
        drive(1'b0, 0, 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b0);
        @(negedge clock);
        check("t4_valid_held", longint'(snap_valid_o), 64'sd1);
        check("t4_lost", longint'(lost_o), 64'sd0);
        ack_snapshot("t4");

        // len=0 (treated as 1), two windows without ack: second dropped
        restart(0);
        drive(1'b1, 7, 1'b0, 1'b0);
        push(7, 7, 0, 1);
        drive(1'b1, 9, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 0, 1'b0, 1'b0);
        @(negedge clock);
        check("t3_lost", longint'(lost_o), 64'sd1);
        check("t3_sum_kept", longint'(sum_o), 64'sd7);
        check("t3_ovf_kept", longint'(ovf_cnt_o), 64'sd0);
        ack_snapshot("t3");

        // Saturation with a 12-bit sum: 4 x 1536 clips to 4095
        restart(4);
        for (int i = 0; i < 4; i++) drive(1'b1, 1536, 1'b1, 1'b0);
        push(4095, 1536, 4, 4);
        ack_snapshot("t5");

        // enable low mid-window discards the partial window
        restart(3);
        drive(1'b1, 500, 1'b0, 1'b0);
        drive(1'b1, 500, 1'b0, 1'b0);
        restart(3);
        drive(1'b1, 1, 1'b0, 1'b0);
        drive(1'b1, 2, 1'b0, 1'b0);
        drive(1'b1, 3, 1'b0, 1'b0);
        push(6, 3, 0, 3);
        ack_snapshot("t6");

        // Reset mid-window: nothing emitted, outputs cleared, lost cleared
        drive(1'b1, 9, 1'b0, 1'b0);
        drive(1'b1, 9, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset   = 1'b1;
        valid_i = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("t7_snap_valid", longint'(snap_valid_o), 64'sd0);
        check("t7_sum", longint'(sum_o), 64'sd0);
        check("t7_lost", longint'(lost_o), 64'sd0);
        // One more sample must start a fresh window, not complete the old one
        drive(1'b1, 9, 1'b0, 1'b0);
        repeat (6) drive(1'b0, 0, 1'b0, 1'b0);
        @(negedge clock);
        check("t7_no_snapshot", longint'(snap_valid_o), 64'sd0);

        check("queue_empty", longint'(q.size()), 64'sd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cluster_count_monitor
